// File: rtl/safe_lock_ctrl.sv
// safe_lock_ctrl -- keypad sequencer for a 4-digit safe-box lock.
//
// Collects key codes into a 4-digit entry buffer that drives the display. A
// completed entry is compared against the stored password. A match opens the
// lock for a timed window. A mismatch counts a failure. MAX_TRIES consecutive
// failures raise a timed alarm lockout.
//
// Optional feature macro: PWD_CHANGE_EN
//   When it is defined, the buffer can be edited while the lock is open, and
//   E with four digits stores a new password. When it is undefined, the
//   password is the constant DEFAULT_PWD.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   key_valid    one-cycle strobe qualifying key_code
//   key_code     0-9 digit, C clear, D backspace, E enter, F reveal toggle
//   p3..p0       entry buffer digits, p0 = most recent
//   digit_valid  bit i set when p<i> holds an entered digit
//   disp_mode    1 = show digits, 0 = show masks
//   unlocked     lock actuator enable
//   alarm        lockout indicator
//   status       state: ENTRY=0 CHECK=1 OPEN=2 FAIL=3 LOCKOUT=4
module safe_lock_ctrl #(
  parameter logic [15:0] DEFAULT_PWD = 16'h1234,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned OPEN_CYCLES = 250000000,
  parameter int unsigned FAIL_CYCLES = 50000000,
  parameter int unsigned LOCK_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] p3,
  output logic [3:0] p2,
  output logic [3:0] p1,
  output logic [3:0] p0,
  output logic [3:0] digit_valid,
  output logic       disp_mode,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] status
);

  localparam logic [2:0] ST_ENTRY   = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  localparam logic [2:0]  MAX_FAIL  = 3'(MAX_TRIES);
  localparam logic [31:0] OPEN_LOAD = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0] FAIL_LOAD = 32'(FAIL_CYCLES - 1);
  localparam logic [31:0] LOCK_LOAD = 32'(LOCK_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [3:0]  dv_q, dv_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        disp_q, disp_d;
  logic        unl_q, unl_d;
  logic        alarm_q, alarm_d;
  logic [2:0]  fail_q, fail_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] pwd;

  logic is_digit, is_clr, is_bksp, is_ent, is_rev;
  logic [15:0] ed_buf;
  logic [3:0]  ed_dv;
  logic [2:0]  ed_cnt;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_clr   = key_valid && (key_code == 4'hC);
  assign is_bksp  = key_valid && (key_code == 4'hD);
  assign is_ent   = key_valid && (key_code == 4'hE);
  assign is_rev   = key_valid && (key_code == 4'hF);

`ifdef PWD_CHANGE_EN
  logic [15:0] pwd_q, pwd_d;
  assign pwd = pwd_q;
`else
  assign pwd = DEFAULT_PWD;
`endif

  // Buffer edit result for digit/backspace/clear. Shared by ENTRY and
  // (optionally) OPEN, so both states edit identically.
  always_comb begin
    ed_buf = buf_q;
    ed_dv  = dv_q;
    ed_cnt = cnt_q;
    if (is_digit && (cnt_q < 3'd4)) begin
      ed_buf = {buf_q[11:0], key_code};
      ed_dv  = {dv_q[2:0], 1'b1};
      ed_cnt = cnt_q + 3'd1;
    end else if (is_bksp && (cnt_q != 3'd0)) begin
      ed_buf = {4'h0, buf_q[15:4]};
      ed_dv  = {1'b0, dv_q[3:1]};
      ed_cnt = cnt_q - 3'd1;
    end else if (is_clr) begin
      ed_buf = '0;
      ed_dv  = '0;
      ed_cnt = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    unl_d   = unl_q;
    alarm_d = alarm_q;
    fail_d  = fail_q;
    timer_d = timer_q;
`ifdef PWD_CHANGE_EN
    pwd_d   = pwd_q;
`endif
    case (state_q)
      ST_ENTRY: begin
        buf_d = ed_buf;
        dv_d  = ed_dv;
        cnt_d = ed_cnt;
        if (is_rev) disp_d = ~disp_q;
        if (is_ent && (cnt_q == 3'd4)) begin
          state_d = ST_CHECK;
          disp_d  = 1'b0;
        end
      end
      ST_CHECK: begin
        buf_d = '0;
        dv_d  = '0;
        cnt_d = '0;
        if (buf_q == pwd) begin
          state_d = ST_OPEN;
          unl_d   = 1'b1;
          fail_d  = '0;
          timer_d = OPEN_LOAD;
        end else if (({1'b0, fail_q} + 4'd1) >= {1'b0, MAX_FAIL}) begin
          state_d = ST_LOCKOUT;
          alarm_d = 1'b1;
          fail_d  = MAX_FAIL;
          timer_d = LOCK_LOAD;
        end else begin
          state_d = ST_FAIL;
          fail_d  = fail_q + 3'd1;
          timer_d = FAIL_LOAD;
        end
      end
      ST_OPEN: begin
`ifdef PWD_CHANGE_EN
        if (is_clr && (cnt_q == 3'd0)) begin
          state_d = ST_ENTRY;
          unl_d   = 1'b0;
          timer_d = '0;
        end else if (is_ent && (cnt_q == 3'd4)) begin
          pwd_d   = buf_q;
          buf_d   = '0;
          dv_d    = '0;
          cnt_d   = '0;
          state_d = ST_ENTRY;
          unl_d   = 1'b0;
          timer_d = '0;
        end else if (is_digit || is_bksp || is_clr) begin
          // Editing keeps the lock open: every edit key restarts the window.
          buf_d   = ed_buf;
          dv_d    = ed_dv;
          cnt_d   = ed_cnt;
          timer_d = OPEN_LOAD;
        end else if (timer_q == 32'd0) begin
          state_d = ST_ENTRY;
          unl_d   = 1'b0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
`else
        if (is_clr || (timer_q == 32'd0)) begin
          state_d = ST_ENTRY;
          unl_d   = 1'b0;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
`endif
      end
      ST_FAIL: begin
        if (timer_q == 32'd0) state_d = ST_ENTRY;
        else                  timer_d = timer_q - 32'd1;
      end
      ST_LOCKOUT: begin
        if (timer_q == 32'd0) begin
          state_d = ST_ENTRY;
          alarm_d = 1'b0;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: begin
        state_d = ST_ENTRY;
        unl_d   = 1'b0;
        alarm_d = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ENTRY;
      buf_q   <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      disp_q  <= 1'b0;
      unl_q   <= 1'b0;
      alarm_q <= 1'b0;
      fail_q  <= '0;
      timer_q <= '0;
`ifdef PWD_CHANGE_EN
      pwd_q   <= DEFAULT_PWD;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      unl_q   <= unl_d;
      alarm_q <= alarm_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
`ifdef PWD_CHANGE_EN
      pwd_q   <= pwd_d;
`endif
    end
  end

  assign p3          = buf_q[15:12];
  assign p2          = buf_q[11:8];
  assign p1          = buf_q[7:4];
  assign p0          = buf_q[3:0];
  assign digit_valid = dv_q;
  assign disp_mode   = disp_q;
  assign unlocked    = unl_q;
  assign alarm       = alarm_q;
  assign status      = state_q;

endmodule
